// File: rtl/fp_mul_pkg.sv
// Shared types, flag indices and special-value builders for the fp multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned FLG_INV = 3;
    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_UNF = 1;
    localparam int unsigned FLG_NX  = 0;

    // Exponent bias for an ew-bit exponent field.
    function automatic int unsigned f_bias(input int unsigned ew);
        return (32'd1 << (ew - 32'd1)) - 32'd1;
    endfunction

    // Signed zero, right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [63:0] f_zero(input logic sign, input int unsigned ew,
                                           input int unsigned mw);
        return 64'(sign) << (ew + mw);
    endfunction

    // Signed infinity, right-aligned in 64 bits.
    function automatic logic [63:0] f_inf(input logic sign, input int unsigned ew,
                                          input int unsigned mw);
        logic [63:0] r;
        r = ((64'd1 << ew) - 64'd1) << mw;
        return r | f_zero(sign, ew, mw);
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
    function automatic logic [63:0] f_qnan(input int unsigned ew, input int unsigned mw);
        return f_inf(1'b0, ew, mw) | (64'd1 << (mw - 32'd1));
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Normalise a raw significand product, round to nearest-even and range-check the exponent.
module fp_round_rne #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [2*(MAN_W+1)-1:0] prod,
    input  logic                   sign,
    input  logic signed [EXP_W+1:0] exp_pre,
    output logic [EXP_W+MAN_W:0]   res_c,
    output logic [3:0]             flags_c
);
    import fp_mul_pkg::*;

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned EXP_PW = EXP_W + 2;

    localparam logic signed [EXP_PW-1:0] EXP_MAX  = EXP_PW'((32'd1 << EXP_W) - 32'd1);
    localparam logic signed [EXP_PW-1:0] EXP_ZERO = '0;

    logic [SIG_W-1:0]         mant;
    logic [SIG_W:0]           mant_r;
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic signed [EXP_PW-1:0] exp_n;
    logic signed [EXP_PW-1:0] exp_f;
    logic [MAN_W-1:0]         frac;

    // Normalise, round, then map out-of-range exponents to inf or zero.
    always_comb begin
        mant     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        exp_n    = exp_pre;
        res_c    = '0;
        flags_c  = '0;
        if (prod[PROD_W-1]) begin
            mant   = prod[PROD_W-1:SIG_W];
            guard  = prod[SIG_W-1];
            sticky = |prod[SIG_W-2:0];
            exp_n  = exp_pre + EXP_PW'(1);
        end else begin
            mant   = prod[PROD_W-2:SIG_W-1];
            guard  = prod[SIG_W-2];
            sticky = |prod[SIG_W-3:0];
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + (SIG_W+1)'(round_up);
        // A carry out of rounding leaves 1.000..0, so renormalise by one.
        exp_f    = exp_n + EXP_PW'(mant_r[SIG_W]);
        frac     = mant_r[SIG_W] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        if (exp_f >= EXP_MAX) begin
            res_c            = W'(f_inf(sign, EXP_W, MAN_W));
            flags_c[FLG_OVF] = 1'b1;
            flags_c[FLG_NX]  = 1'b1;
        end else if (exp_f <= EXP_ZERO) begin
            res_c            = W'(f_zero(sign, EXP_W, MAN_W));
            flags_c[FLG_UNF] = 1'b1;
            flags_c[FLG_NX]  = 1'b1;
        end else begin
            res_c           = {sign, exp_f[EXP_W-1:0], frac};
            flags_c[FLG_NX] = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative shift-add floating-point multiplier behind a valid/ready handshake.
module fp_mul_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] k,
    output logic [3:0]           flags
);
    import fp_mul_pkg::*;

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned EXP_PW = EXP_W + 2;
    localparam int unsigned CNT_W  = $clog2(SIG_W + 1);

    state_e                   state_q, state_d;
    logic [PROD_W-1:0]        a_q, a_d;
    logic [SIG_W-1:0]         b_q, b_d;
    logic [PROD_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sign_q, sign_d;
    logic signed [EXP_PW-1:0] exp_q, exp_d;
    logic [W-1:0]             k_q, k_d;
    logic [3:0]               flags_q, flags_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic [EXP_W-1:0] xe, ye;
    logic [MAN_W-1:0] xf, yf;
    logic             x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, op_sign;
    logic [W-1:0]     rnd_res;
    logic [3:0]       rnd_flags;

    assign xe      = x[W-2:MAN_W];
    assign ye      = y[W-2:MAN_W];
    assign xf      = x[MAN_W-1:0];
    assign yf      = y[MAN_W-1:0];
    assign x_nan   = (&xe) & (|xf);
    assign y_nan   = (&ye) & (|yf);
    assign x_inf   = (&xe) & ~(|xf);
    assign y_inf   = (&ye) & ~(|yf);
    assign x_zero  = ~(|xe);
    assign y_zero  = ~(|ye);
    assign op_sign = x[W-1] ^ y[W-1];

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod    (acc_q),
        .sign    (sign_q),
        .exp_pre (exp_q),
        .res_c   (rnd_res),
        .flags_c (rnd_flags)
    );

    // State register and datapath flops; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            k_q         <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            k_q         <= k_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath: special decode on accept, one multiplier bit per MUL cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        k_d     = k_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = op_sign;
                    flags_d = '0;
                    state_d = DONE;
                    if (x_nan || y_nan) begin
                        k_d = W'(f_qnan(EXP_W, MAN_W));
                    end else if ((x_inf && y_zero) || (y_inf && x_zero)) begin
                        k_d              = W'(f_qnan(EXP_W, MAN_W));
                        flags_d[FLG_INV] = 1'b1;
                    end else if (x_inf || y_inf) begin
                        k_d = W'(f_inf(op_sign, EXP_W, MAN_W));
                    end else if (x_zero || y_zero) begin
                        k_d = W'(f_zero(op_sign, EXP_W, MAN_W));
                    end else begin
                        a_d     = PROD_W'({1'b1, xf});
                        b_d     = {1'b1, yf};
                        acc_d   = '0;
                        cnt_d   = CNT_W'(SIG_W);
                        exp_d   = EXP_PW'(xe) + EXP_PW'(ye) - EXP_PW'(f_bias(EXP_W));
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                k_d     = rnd_res;
                flags_d = rnd_flags;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign k         = k_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Self-checking bench for fp_mul_iter: directed corner cases plus random operands vs a value model.
module tb_fp_mul_iter;

    localparam int unsigned MAN_W = 23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] x, y, k;
    logic [3:0]  flags;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] x2, y2, k2;
    logic [3:0]  flags2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .k         (k),
        .flags     (flags)
    );

    fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut_half (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .x         (x2),
        .y         (y2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .k         (k2),
        .flags     (flags2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Value model for single precision: exact integer product, then RNE by remainder vs half-ulp.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int               ea, eb, e, msb, sh;
        logic             s, a_nan, b_nan, a_inf, b_inf;
        longint unsigned  p, q, rem, half;
        s     = a[31] ^ b[31];
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 23'd0);
        b_nan = (eb == 255) && (b[22:0] != 23'd0);
        a_inf = (ea == 255) && (a[22:0] == 23'd0);
        b_inf = (eb == 255) && (b[22:0] == 23'd0);
        if (a_nan || b_nan) return {4'b0000, 32'h7FC00000};
        if ((a_inf && eb == 0) || (b_inf && ea == 0)) return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
        if (ea == 0 || eb == 0) return {4'b0000, s, 31'd0};
        p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        msb  = p[47] ? 47 : 46;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        e = ea + eb - 127 + (msb - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, (rem != 64'd0), s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        sel = int'($urandom_range(0, 15));
        f   = 23'($urandom);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = 23'd0;
        end else e = 8'($urandom_range(40, 214));
        return {1'($urandom), e, f};
    endfunction

    // Present operands once in_ready is seen, then drop in_valid after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        x        = a;
        y        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid; specials are already DONE at the accept edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ek, input logic [3:0] ef, input int elat);
        int lat;
        start_op(a, b);
        wait_done(lat);
        check({tag, "_k"}, 64'(k), 64'(ek));
        check({tag, "_flags"}, 64'(flags), 64'(ef));
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        handoff();
    endtask

    initial begin
        int          lat;
        logic [31:0] a, b;
        logic [35:0] r;
        int          elat;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        x          = '0;
        y          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        x2         = '0;
        y2         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_k", 64'(k), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_dir("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, MAN_W + 2);
        run_dir("rne_down", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, MAN_W + 2);
        run_dir("tie_odd_up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, MAN_W + 2);
        run_dir("tie_even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, MAN_W + 2);
        run_dir("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, MAN_W + 2);
        run_dir("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, MAN_W + 2);
        run_dir("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
        run_dir("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0);
        run_dir("nan_x_1", 32'h7FA00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 0);
        run_dir("neg_x_subn", 32'hBF800000, 32'h00012345, 32'h80000000, 4'b0000, 0);

        // Backpressure: result held while out_ready is low; a new request is ignored.
        start_op(32'h3FC00000, 32'h40000000);
        wait_done(lat);
        check("bp_lat", 64'(lat), 64'(MAN_W + 2));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x        = 32'h12345678;
            y        = 32'h3F800000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_k", 64'(k), 64'h40400000);
            check("bp_flags", 64'(flags), 64'(0));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'(0));
        check("bp_release_ready", 64'(in_ready), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_stray_op", 64'(out_valid), 64'(0));

        // Reset in the middle of the shift-add phase.
        start_op(32'h3FC00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_k", 64'(k), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_dir("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, MAN_W + 2);

        // Random operands against the value model.
        for (int i = 0; i < 60; i++) begin
            a    = rnd_operand();
            b    = rnd_operand();
            r    = ref_mul(a, b);
            elat = (a[30:23] == 8'h00 || a[30:23] == 8'hFF ||
                    b[30:23] == 8'h00 || b[30:23] == 8'hFF) ? 0 : MAN_W + 2;
            start_op(a, b);
            wait_done(lat);
            check("rnd_k", 64'(k), 64'(r[31:0]));
            check("rnd_flags", 64'(flags), 64'(r[35:32]));
            check("rnd_lat", 64'(lat), 64'(elat));
            handoff();
        end

        // Half-precision-like instance: 1.5 * 2.0 = 3.0, then inf * 0.
        @(negedge clk);
        check("h_in_ready", 64'(in_ready2), 64'(1));
        x2        = 16'h3E00;
        y2        = 16'h4000;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("h_k", 64'(k2), 64'h4200);
        check("h_flags", 64'(flags2), 64'(0));
        check("h_lat", 64'(lat), 64'(12));
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1 out_ready2 = 1'b0;
        @(negedge clk);
        x2        = 16'h7C00;
        y2        = 16'h0000;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        check("h_inv_valid", 64'(out_valid2), 64'(1));
        check("h_inv_k", 64'(k2), 64'h7E00);
        check("h_inv_flags", 64'(flags2), 64'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
